serial_uart_bridge: RTL and testbench

//   Peripheral end of the processor's byte-serial IO port (serial_* ports on data_memory).

---
 rtl/serial_uart_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_uart_bridge.sv
`default_nettype none
// =============================================================================
// Module   : serial_uart_bridge
// Purpose  : CPU byte-port to UART 8N1 bridge with TX/RX FIFOs (first-word
//            fall-through). The RX path is built only when SERIAL_RX_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================

module serial_uart_bridge_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_w, pop_w;

    // Flags come from the registered count, so a push on a full FIFO is refused
    // even if a pop happens in the same cycle.
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign push_w  = push_i & ~full_o;
    assign pop_w   = pop_i & ~empty_o;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push_w) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_w} - {{AW{1'b0}}, pop_w};
        end
    end
endmodule

module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] serial_out,
    input  logic       serial_wren_out,
    input  logic       serial_rden_out,
    output logic [7:0] serial_in,
    output logic       serial_valid_in,
    output logic       serial_ready_in,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_frame_err,
    output logic       rx_overrun
);
    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    uart_state_t   tx_state_q, tx_state_d;
    logic [TW-1:0] tx_timer_q, tx_timer_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_pop_w, tx_empty_w, tx_full_w;
    logic [7:0]    tx_head_w;

    serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (serial_wren_out),
        .data_i  (serial_out),
        .pop_i   (tx_pop_w),
        .head_o  (tx_head_w),
        .empty_o (tx_empty_w),
        .full_o  (tx_full_w)
    );

    assign serial_ready_in = ~tx_full_w;
    assign uart_txd        = txd_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop_w   = 1'b0;
        case (tx_state_q)
            ST_IDLE: if (!tx_empty_w) begin
                tx_pop_w   = 1'b1;
                tx_shift_d = tx_head_w;
                tx_timer_d = '0;
                tx_state_d = ST_START;
            end
            ST_START: if (tx_timer_q == BIT_LAST) begin
                tx_timer_d = '0;
                tx_bit_d   = 3'd0;
                tx_state_d = ST_DATA;
            end else tx_timer_d = tx_timer_q + 1'b1;
            ST_DATA: if (tx_timer_q == BIT_LAST) begin
                tx_timer_d = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                else                  tx_bit_d   = tx_bit_q + 1'b1;
            end else tx_timer_d = tx_timer_q + 1'b1;
            ST_STOP: if (tx_timer_q == BIT_LAST) begin
                tx_timer_d = '0;
                tx_state_d = ST_IDLE;
            end else tx_timer_d = tx_timer_q + 1'b1;
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Line level follows the current state one cycle later (registered output).
    always_comb begin
        txd_d = 1'b1;
        if (tx_state_q == ST_START)     txd_d = 1'b0;
        else if (tx_state_q == ST_DATA) txd_d = tx_shift_q[0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_timer_q <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

`ifdef SERIAL_RX_EN
    uart_state_t   rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic          rx_push_w, rx_empty_w, rx_full_w;

    serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rx_push_w),
        .data_i  (rx_shift_q),
        .pop_i   (serial_rden_out),
        .head_o  (serial_in),
        .empty_o (rx_empty_w),
        .full_o  (rx_full_w)
    );

    assign serial_valid_in = ~rx_empty_w;
    assign rx_frame_err    = frame_err_q;
    assign rx_overrun      = overrun_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_timer_d  = rx_timer_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_w   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (rx_state_q)
            // Edge-triggered start: a line stuck low never re-enters START.
            ST_IDLE: if (rx_prev_q && !rx_sync2_q) begin
                rx_timer_d = '0;
                rx_state_d = ST_START;
            end
            ST_START: if (rx_timer_q == HALF_LAST) begin
                rx_timer_d = '0;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
            end else rx_timer_d = rx_timer_q + 1'b1;
            ST_DATA: if (rx_timer_q == BIT_LAST) begin
                rx_timer_d = '0;
                rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else rx_timer_d = rx_timer_q + 1'b1;
            ST_STOP: if (rx_timer_q == BIT_LAST) begin
                rx_timer_d = '0;
                rx_state_d = ST_IDLE;
                if (!rx_sync2_q)    frame_err_d = 1'b1;
                else if (rx_full_w) overrun_d   = 1'b1;
                else                rx_push_w   = 1'b1;
            end else rx_timer_d = rx_timer_q + 1'b1;
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q  <= ST_IDLE;
            rx_timer_q  <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_timer_q  <= rx_timer_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_sync1_q  <= uart_rxd;
            rx_sync2_q  <= rx_sync1_q;
            rx_prev_q   <= rx_sync2_q;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end
`else
    logic unused_rx;
    assign unused_rx       = ^{uart_rxd, serial_rden_out};
    assign serial_in       = 8'h00;
    assign serial_valid_in = 1'b0;
    assign rx_frame_err    = 1'b0;
    assign rx_overrun      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_uart_bridge.sv
`default_nettype none
// =============================================================================
// Module   : tb_serial_uart_bridge
// Purpose  : Table vectors, hand sequences and random TX traffic checked against a
//            frame-timing model; RX expectations follow SERIAL_RX_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_serial_uart_bridge;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] serial_out = 8'h00;
    logic       serial_wren_out = 1'b0;
    logic       serial_rden_out = 1'b0;
    logic [7:0] serial_in;
    logic       serial_valid_in, serial_ready_in;
    logic       uart_rxd = 1'b1;
    logic       uart_txd, rx_frame_err, rx_overrun;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .serial_rden_out (serial_rden_out),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_ready_in (serial_ready_in),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd),
        .rx_frame_err    (rx_frame_err),
        .rx_overrun      (rx_overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // TX model: each accepted byte gets the cycle its start bit appears on the line.
    int         m_edge[$];
    int         m_start[$];
    logic [7:0] m_data[$];

    function automatic logic model_txd(input int t);
        for (int i = 0; i < m_start.size(); i++) begin
            if (t >= m_start[i] && t < m_start[i] + FRAME) begin
                int j;
                j = (t - m_start[i]) / CPB;
                if (j == 0) return 1'b0;
                if (j == 9) return 1'b1;
                return m_data[i][j-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic model_ready(input int t);
        int n;
        n = 0;
        for (int i = 0; i < m_edge.size(); i++) begin
            if (m_edge[i] <= t)        n++;
            if (m_start[i] - 1 <= t)   n--;
        end
        return n < DEPTH;
    endfunction

    task automatic model_clear();
        m_edge.delete();
        m_start.delete();
        m_data.delete();
    endtask

    // Called at a falling edge: the write is sampled on the next rising edge.
    task automatic drive_write(input logic [7:0] d);
        int e, s;
        serial_wren_out = 1'b1;
        serial_out      = d;
        e = cyc + 1;
        if (model_ready(cyc)) begin
            s = e + 2;
            if (m_start.size() > 0 && m_start[$] + FRAME + 1 > s) s = m_start[$] + FRAME + 1;
            m_edge.push_back(e);
            m_start.push_back(s);
            m_data.push_back(d);
        end
    endtask

    bit chk_en = 1'b0;
    always @(negedge clock) begin
        if (chk_en) begin
            check("txd_model", 32'(uart_txd), 32'(model_txd(cyc)));
            check("ready_model", 32'(serial_ready_in), 32'(model_ready(cyc)));
        end
    end

    int seen_ferr = 0;
    int seen_ovr  = 0;
    always @(negedge clock) begin
        if (rx_frame_err === 1'b1) seen_ferr <= seen_ferr + 1;
        if (rx_overrun === 1'b1)   seen_ovr  <= seen_ovr + 1;
    end

    logic [7:0] rxq[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;

    // Leaves the line at the stop-bit level.
    task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clock);
`ifdef SERIAL_RX_EN
        if (!stop_bit)                exp_ferr++;
        else if (rxq.size() < DEPTH)  rxq.push_back(d);
        else                          exp_ovr++;
`endif
    endtask

    task automatic rx_drain(input string name);
        repeat (3) @(negedge clock);
        while (rxq.size() > 0) begin
            check({name, "_valid"}, 32'(serial_valid_in), 32'(1));
            check({name, "_data"}, 32'(serial_in), 32'(rxq[0]));
            serial_rden_out = 1'b1;
            @(negedge clock);
            serial_rden_out = 1'b0;
            void'(rxq.pop_front());
        end
        check({name, "_empty_valid"}, 32'(serial_valid_in), 32'(0));
        check({name, "_empty_data"}, 32'(serial_in), 32'(0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits in time order from bit 0: start, d0..d7, stop
    } tx_vec_t;

    tx_vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_head;
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h01, 10'h202};

        // Reset held with activity on every input.
        #1 reset = 1'b0;
        serial_wren_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            uart_rxd   = ~uart_rxd;
            serial_out = 8'($urandom);
            check("rst_txd", 32'(uart_txd), 32'(1));
            check("rst_valid", 32'(serial_valid_in), 32'(0));
            check("rst_ready", 32'(serial_ready_in), 32'(1));
            check("rst_data", 32'(serial_in), 32'(0));
        end
        @(negedge clock);
        reset = 1'b1;
        serial_wren_out = 1'b0;
        uart_rxd = 1'b1;
        model_clear();
        chk_en = 1'b1;
        repeat (10) @(negedge clock);
        check("post_rst_valid", 32'(serial_valid_in), 32'(0));

        // Single frames against hand-written line patterns.
        for (int v = 0; v < 5; v++) begin
            drive_write(vecs[v].data);
            @(negedge clock);
            serial_wren_out = 1'b0;
            for (int k = 0; k < 44; k++) begin
                logic exp_bit;
                exp_bit = 1'b1;
                if (k >= 2 && k < 2 + FRAME) exp_bit = vecs[v].frame[(k - 2) / CPB];
                check($sformatf("vec%0d_txd_k%0d", v, k), 32'(uart_txd), 32'(exp_bit));
                @(negedge clock);
            end
        end

        // 18 back-to-back writes: first is popped, 16 fill the FIFO, the 18th drops.
        for (int i = 0; i < 18; i++) begin
            drive_write(8'(i));
            @(negedge clock);
            check($sformatf("burst_ready_%0d", i), 32'(serial_ready_in), 32'(i < 16));
        end
        serial_wren_out = 1'b0;
        repeat (17 * (FRAME + 1) + 10) @(negedge clock);

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) begin
            drive_write(8'h00);
            @(negedge clock);
        end
        serial_wren_out = 1'b0;
        repeat (14) @(negedge clock);
        check("midrst_before_txd", 32'(uart_txd), 32'(0));
        #2;
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("midrst_txd", 32'(uart_txd), 32'(1));
        check("midrst_ready", 32'(serial_ready_in), 32'(1));
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        chk_en = 1'b1;
        repeat (60) @(negedge clock);

        // Random TX traffic: heavy then light.
        for (int c = 0; c < 1500; c++) begin
            if ((c < 800) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0))
                drive_write(8'($urandom));
            else
                serial_wren_out = 1'b0;
            @(negedge clock);
        end
        serial_wren_out = 1'b0;
        repeat (17 * (FRAME + 1) + 5) @(negedge clock);

        // RX: one frame, then read it.
        rx_frame(8'h3C, 1'b1);
        uart_rxd = 1'b1;
        repeat (3) @(negedge clock);
`ifdef SERIAL_RX_EN
        exp_head = 8'h3C;
`else
        exp_head = 8'h00;
`endif
        check("rx3c_valid", 32'(serial_valid_in), 32'(exp_head != 8'h00));
        check("rx3c_data", 32'(serial_in), 32'(exp_head));
        rx_drain("rx3c");

        // RX: 17 frames without reads -> 16 stored, one overrun.
        for (int f = 0; f < 17; f++) begin
            rx_frame(8'($urandom), 1'b1);
            uart_rxd = 1'b1;
            repeat (2) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        check("rx_overrun_count", 32'(seen_ovr), 32'(exp_ovr));
        rx_drain("rx_fill");

        // RX: framing error with the line held low afterwards.
        rx_frame(8'h55, 1'b0);
        repeat (12) @(negedge clock);
        uart_rxd = 1'b1;
        repeat (6) @(negedge clock);
        check("rx_ferr_count", 32'(seen_ferr), 32'(exp_ferr));
        check("rx_ferr_valid", 32'(serial_valid_in), 32'(0));

        // RX: one-cycle low glitch is not a start bit.
        uart_rxd = 1'b0;
        @(negedge clock);
        uart_rxd = 1'b1;
        repeat (FRAME + 10) @(negedge clock);
        check("rx_glitch_valid", 32'(serial_valid_in), 32'(0));
        check("rx_glitch_ferr", 32'(seen_ferr), 32'(exp_ferr));

        // RX: random frames with random stop bits.
        for (int f = 0; f < 8; f++) begin
            rx_frame(8'($urandom), 1'($urandom_range(0, 3) != 0));
            uart_rxd = 1'b1;
            repeat (3) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        check("rx_rand_ferr", 32'(seen_ferr), 32'(exp_ferr));
        check("rx_rand_ovr", 32'(seen_ovr), 32'(exp_ovr));
        rx_drain("rx_rand");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
